// File: rtl/dbus_sramlike.sv
// dbus_sramlike: bridges core load/store requests onto an SRAM-like bus, one bus transaction per request
//   clk, reset                     : clock, synchronous active-high reset
//   mread_* / mwrite_*             : level-held core load / store requests (store wins a tie)
//   rd, d_data_ok, d_ok_is_write   : registered completion pulse and returned word to the core
//   data_req ... data_wstrb        : SRAM-like master request side, driven from captured registers
//   data_addr_ok, data_data_ok,
//   data_rdata                     : SRAM-like slave responses
module dbus_sramlike #(
    parameter logic MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mread_valid,
    input  logic [31:0] mread_addr,
    input  logic [1:0]  mread_size,
    input  logic        mwrite_valid,
    input  logic [31:0] mwrite_addr,
    input  logic [1:0]  mwrite_size,
    input  logic [31:0] mwrite_data,
    output logic [31:0] rd,
    output logic        d_data_ok,
    output logic        d_ok_is_write,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      r_state, w_next;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rd;
    logic [3:0]  r_wstrb;
    logic        w_take, w_resp;
    logic [31:0] w_addr, w_paddr;
    logic [1:0]  w_size;
    logic [3:0]  w_strb;
    always_comb begin
        w_take  = r_state == IDLE && (mwrite_valid || mread_valid);
        w_addr  = mwrite_valid ? mwrite_addr : mread_addr;
        w_size  = mwrite_valid ? mwrite_size : mread_size;
        // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) fold onto the low 512 MB
        w_paddr = (MAP_KSEG && w_addr[31:30] == 2'b10) ? (w_addr & 32'h1FFF_FFFF) : w_addr;
        w_strb  = !mwrite_valid ? 4'b0000 :
                  mwrite_size == 2'd0 ? 4'b0001 << mwrite_addr[1:0] :
                  mwrite_size == 2'd1 ? (mwrite_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // responses outside REQ/WAIT are strays and must not touch rd
        w_resp  = (r_state == REQ && data_addr_ok && data_data_ok) || (r_state == WAIT && data_data_ok);
        w_next  = r_state;
        case (r_state)
            IDLE:    w_next = w_take ? REQ : IDLE;
            REQ:     w_next = data_addr_ok ? (data_data_ok ? DONE : WAIT) : REQ;
            WAIT:    w_next = data_data_ok ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_rd    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_wr    <= mwrite_valid;
                r_size  <= w_size;
                r_addr  <= w_paddr;
                r_wdata <= mwrite_data;
                r_wstrb <= w_strb;
            end
            if (w_resp) r_rd <= data_rdata;
        end
    end
    assign rd            = r_rd;
    assign d_data_ok     = r_state == DONE;
    assign d_ok_is_write = r_state == DONE && r_wr;
    assign data_req      = r_state == REQ;
    assign data_wr       = r_wr;
    assign data_size     = r_size;
    assign data_addr     = r_addr;
    assign data_wdata    = r_wdata;
    assign data_wstrb    = r_wstrb;
endmodule

// File: tb/tb_dbus_sramlike.sv
// tb_dbus_sramlike: directed bench with a transaction-level scoreboard for dbus_sramlike
module tb_dbus_sramlike;
    logic        clk = 1'b0, reset = 1'b1;
    logic        mread_valid = 1'b0, mwrite_valid = 1'b0;
    logic [31:0] mread_addr = 32'd0, mwrite_addr = 32'd0, mwrite_data = 32'd0;
    logic [1:0]  mread_size = 2'd0, mwrite_size = 2'd0;
    logic [31:0] rd, data_addr, data_wdata;
    logic        d_data_ok, d_ok_is_write, data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;
    int n_checks = 0, n_errors = 0;

    dbus_sramlike dut (
        .clk(clk), .reset(reset),
        .mread_valid(mread_valid), .mread_addr(mread_addr), .mread_size(mread_size),
        .mwrite_valid(mwrite_valid), .mwrite_addr(mwrite_addr), .mwrite_size(mwrite_size),
        .mwrite_data(mwrite_data),
        .rd(rd), .d_data_ok(d_data_ok), .d_ok_is_write(d_ok_is_write),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } txn_t;

    txn_t pend[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        txn_t t;
        int sh;
        sh = int'(a % 32'd4);
        t.wr    = wr;
        t.size  = sz;
        t.wdata = wd;
        t.addr  = (a >= 32'h8000_0000 && a < 32'hC000_0000) ? a % 32'h2000_0000 : a;
        t.strb  = !wr ? 4'h0 : sz == 2'd0 ? 4'(1 << sh) : sz == 2'd1 ? (sh >= 2 ? 4'hC : 4'h3) : 4'hF;
        return t;
    endfunction

    // scoreboard: expected completion and rd follow purely from the bus handshake history
    logic        armed = 1'b0, post_rst = 1'b0, accepted = 1'b0, done_due = 1'b0, done_wr = 1'b0;
    logic [31:0] m_rd = 32'd0;
    txn_t        cur;

    always @(negedge clk) begin
        if (armed) begin
            chk("m_dok", d_data_ok, done_due);
            chk("m_rd", rd, m_rd);
            if (done_due) chk("m_dwr", d_ok_is_write, done_wr);
            if (post_rst) begin
                chk("m_rst_wr", data_wr, 0);
                chk("m_rst_addr", data_addr, 0);
                chk("m_rst_wdata", data_wdata, 0);
                chk("m_rst_strb", data_wstrb, 0);
                chk("m_rst_size", data_size, 0);
            end
            if (accepted || done_due || pend.size() == 0) chk("m_req_idle", data_req, 0);
            else if (data_req) begin
                chk("m_wr", data_wr, pend[0].wr);
                chk("m_addr", data_addr, pend[0].addr);
                chk("m_size", data_size, pend[0].size);
                chk("m_strb", data_wstrb, pend[0].strb);
                if (pend[0].wr) chk("m_wdata", data_wdata, pend[0].wdata);
            end
        end
        done_due = 1'b0;
        post_rst = 1'b0;
        if (reset) begin
            armed = 1'b1;
            post_rst = 1'b1;
            accepted = 1'b0;
            m_rd = 32'd0;
            pend.delete();
        end else if (armed) begin
            if (accepted && data_data_ok) begin
                accepted = 1'b0;
                done_due = 1'b1;
                done_wr  = cur.wr;
                m_rd     = data_rdata;
            end else if (!accepted && data_req && data_addr_ok && pend.size() > 0) begin
                cur = pend.pop_front();
                if (data_data_ok) begin
                    done_due = 1'b1;
                    done_wr  = cur.wr;
                    m_rd     = data_rdata;
                end else accepted = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [31:0] rdat);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = rdat;
        tick(1);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    // one request: addr_ok after aw extra REQ cycles, data_ok dw cycles after addr_ok
    task automatic xact(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                        input int aw, input int dw, input logic [31:0] rdat,
                        input logic [31:0] ea, input logic [3:0] es);
        pend.push_back(mk(wr, a, sz, wd));
        if (wr) begin
            mwrite_valid = 1'b1; mwrite_addr = a; mwrite_size = sz; mwrite_data = wd;
        end else begin
            mread_valid = 1'b1; mread_addr = a; mread_size = sz;
        end
        tick(1);
        chk("req", data_req, 1);
        chk("addr", data_addr, ea);
        chk("strb", data_wstrb, es);
        if (aw > 0) tick(aw);
        chk("req_held", data_req, 1);
        data_addr_ok = 1'b1;
        if (dw == 0) begin
            data_data_ok = 1'b1;
            data_rdata   = rdat;
        end
        tick(1);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (dw > 0) begin
            chk("req_drop", data_req, 0);
            if (dw > 1) tick(dw - 1);
            data_data_ok = 1'b1;
            data_rdata   = rdat;
            tick(1);
            data_data_ok = 1'b0;
        end
        chk("dok", d_data_ok, 1);
        chk("dwr", d_ok_is_write, wr);
        chk("rd", rd, rdat);
        mread_valid  = 1'b0;
        mwrite_valid = 1'b0;
        tick(1);
        chk("dok_end", d_data_ok, 0);
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        chk("rst_req", data_req, 0);
        chk("rst_dok", d_data_ok, 0);
        chk("rst_rd", rd, 0);
        chk("rst_addr", data_addr, 0);
        tick(1);
        // zero-wait load through kseg0
        xact(1'b0, 32'h8000_1004, 2'd2, 32'd0, 0, 0, 32'hDEAD_BEEF, 32'h0000_1004, 4'h0);
        // byte store through kseg1 with address and data waits
        xact(1'b1, 32'hA000_0003, 2'd0, 32'h7700_0000, 3, 2, 32'h1234_5678, 32'h0000_0003, 4'b1000);
        // simultaneous: store first, load after the next IDLE
        pend.push_back(mk(1'b1, 32'h0000_0100, 2'd2, 32'hCAFE_F00D));
        pend.push_back(mk(1'b0, 32'h0000_0200, 2'd2, 32'd0));
        mwrite_valid = 1'b1; mwrite_addr = 32'h0000_0100; mwrite_size = 2'd2; mwrite_data = 32'hCAFE_F00D;
        mread_valid  = 1'b1; mread_addr  = 32'h0000_0200; mread_size  = 2'd2;
        tick(1);
        chk("sim_wr", data_wr, 1);
        chk("sim_waddr", data_addr, 32'h0000_0100);
        respond(32'h1111_1111);
        chk("sim_dok1", d_data_ok, 1);
        chk("sim_dwr1", d_ok_is_write, 1);
        mwrite_valid = 1'b0;
        tick(1);
        chk("sim_idle", data_req, 0);
        tick(1);
        chk("sim_req2", data_req, 1);
        chk("sim_rd_wr", data_wr, 0);
        chk("sim_raddr", data_addr, 32'h0000_0200);
        respond(32'hA5A5_A5A5);
        chk("sim_dok2", d_data_ok, 1);
        chk("sim_dwr2", d_ok_is_write, 0);
        chk("sim_rd", rd, 32'hA5A5_A5A5);
        mread_valid = 1'b0;
        tick(1);
        // held valid through DONE: re-captured only in the following IDLE
        pend.push_back(mk(1'b0, 32'hBFC0_0010, 2'd2, 32'd0));
        mread_valid = 1'b1; mread_addr = 32'hBFC0_0010; mread_size = 2'd2;
        tick(1);
        chk("held_addr", data_addr, 32'h1FC0_0010);
        respond(32'h0BAD_F00D);
        chk("held_dok", d_data_ok, 1);
        chk("held_req_done", data_req, 0);
        pend.push_back(mk(1'b0, 32'hBFC0_0010, 2'd2, 32'd0));
        tick(1);
        chk("held_idle_dok", d_data_ok, 0);
        chk("held_idle_req", data_req, 0);
        tick(1);
        chk("held_req2", data_req, 1);
        respond(32'h600D_CAFE);
        chk("held_dok2", d_data_ok, 1);
        chk("held_rd2", rd, 32'h600D_CAFE);
        mread_valid = 1'b0;
        tick(1);
        // mapping boundaries and strobes
        xact(1'b0, 32'h1FC0_0000, 2'd2, 32'd0, 0, 0, 32'h0000_0001, 32'h1FC0_0000, 4'h0);
        xact(1'b0, 32'hC000_0000, 2'd2, 32'd0, 1, 0, 32'h0000_0002, 32'hC000_0000, 4'h0);
        xact(1'b0, 32'hBFFF_FFFC, 2'd2, 32'd0, 0, 1, 32'h0000_0003, 32'h1FFF_FFFC, 4'h0);
        xact(1'b0, 32'h7FFF_FFFC, 2'd2, 32'd0, 0, 0, 32'h0000_0004, 32'h7FFF_FFFC, 4'h0);
        xact(1'b1, 32'h0000_0002, 2'd1, 32'hBEEF_0000, 1, 1, 32'h0000_0005, 32'h0000_0002, 4'b1100);
        xact(1'b1, 32'h0000_0000, 2'd1, 32'h0000_BEEF, 0, 0, 32'h0000_0006, 32'h0000_0000, 4'b0011);
        xact(1'b1, 32'h0000_0001, 2'd0, 32'h0000_5500, 0, 0, 32'h0000_0007, 32'h0000_0001, 4'b0010);
        xact(1'b1, 32'h0000_0005, 2'd3, 32'h0102_0304, 0, 0, 32'h0000_0008, 32'h0000_0005, 4'b1111);
        // reset in WAIT, then a stray data_ok in IDLE
        pend.push_back(mk(1'b0, 32'h8000_0040, 2'd2, 32'd0));
        mread_valid = 1'b1; mread_addr = 32'h8000_0040; mread_size = 2'd2;
        tick(1);
        data_addr_ok = 1'b1;
        tick(1);
        data_addr_ok = 1'b0;
        chk("rst_wait_req", data_req, 0);
        reset = 1'b1;
        mread_valid = 1'b0;
        tick(1);
        reset = 1'b0;
        chk("abort_req", data_req, 0);
        chk("abort_rd", rd, 0);
        tick(1);
        data_data_ok = 1'b1;
        data_rdata = 32'hFFFF_FFFF;
        tick(1);
        data_data_ok = 1'b0;
        chk("stray_dok", d_data_ok, 0);
        chk("stray_rd", rd, 0);
        tick(1);
        chk("stray_dok2", d_data_ok, 0);
        chk("stray_rd2", rd, 0);
        xact(1'b0, 32'h0000_0010, 2'd2, 32'd0, 0, 0, 32'h0000_0099, 32'h0000_0010, 4'h0);
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dbus_sramlike.md
# dbus_sramlike

Data-side memory responder for the out-of-order core. It accepts the core's level-held load request (`mread`) and store request (`mwrite`) and answers with the returned word `rd` and the one-cycle completion strobe `d_data_ok`. On its far side it acts as an SRAM-like bus master (req / addr_ok / data_ok), and it sits between the core datapath and the AXI/SRAM-like crossbar. It arbitrates load against store, translates unmapped kseg addresses, generates write strobes, and guarantees exactly one bus transaction per core request.

## Interface
Parameters:
- `MAP_KSEG`, default 1: when 1, addresses 0x8000_0000–0xBFFF_FFFF are mapped to `addr & 32'h1FFF_FFFF`; all other addresses pass unchanged. When 0, every address passes unchanged.

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `mread_valid` in 1: load request, held by the core until it samples `d_data_ok`.
- `mread_addr` in 32: load virtual address.
- `mread_size` in 2: 0 = byte, 1 = half, 2 = word.
- `mwrite_valid` in 1: store request, held by the core until it samples `d_data_ok`.
- `mwrite_addr` in 32: store virtual address.
- `mwrite_size` in 2: same encoding as `mread_size`.
- `mwrite_data` in 32: store data, already lane-aligned by the core.
- `rd` out 32: raw read word, valid while `d_data_ok` is 1.
- `d_data_ok` out 1: one-cycle completion pulse.
- `d_ok_is_write` out 1: qualifies `d_data_ok`; 1 = the store completed, 0 = the load completed.
- `data_req` out 1: SRAM-like request.
- `data_wr` out 1: 1 = write transaction.
- `data_size` out 2: transaction size.
- `data_addr` out 32: physical address.
- `data_wdata` out 32: write data.
- `data_wstrb` out 4: byte enables for the write.
- `data_addr_ok` in 1: slave has accepted the address.
- `data_data_ok` in 1: slave has returned data or acknowledged the write.
- `data_rdata` in 32: read data from the slave.

## Operation
- FSM states are IDLE, REQ, WAIT and DONE. Reset forces IDLE from any state.
- **IDLE:**
  - If `mwrite_valid` is 1, capture the write fields into the request registers. The write wins when both requests are valid, because it is the older, retiring instruction.
  - Otherwise, if `mread_valid` is 1, capture the read fields.
  - Move to REQ when either request was captured; otherwise stay in IDLE.
- **REQ:**
  - `data_req` = 1. All `data_*` outputs come from the captured registers only, so core input changes are ignored.
  - If `data_addr_ok` and `data_data_ok` are both 1, latch `rdata` and go to DONE.
  - If only `data_addr_ok` is 1, go to WAIT.
  - If neither, stay in REQ.
- **WAIT:**
  - `data_req` = 0.
  - On `data_data_ok`, latch `data_rdata` into `rd` and go to DONE. Latch it for writes too; the value is don't-care.
- **DONE:**
  - `d_data_ok` = 1 and `d_ok_is_write` = the captured `wr` bit.
  - Core valids are ignored in this state, so a request cannot be re-issued in its own completion cycle.
  - Next state is always IDLE.
- **Address mapping:** applied when the request is captured. `data_addr` holds the full address with its low bits intact.
- **Write strobe** (from size and `addr[1:0]`):
  - byte: `4'b0001 << addr[1:0]`
  - half: `addr[1]` ? `4'b1100` : `4'b0011`
  - word: `4'b1111`
  - Size 3 is treated as word.
  - For reads, `data_wstrb` = 0.
- **Stray responses:** a `data_data_ok` arriving in IDLE or DONE (for example after a reset mid-transaction) is ignored. It neither changes `rd` nor pulses `d_data_ok`.
- **Misaligned addresses:** passed through unchecked. The core raises the exception before issuing the request.

## Timing
- **Reset values:**
  - state = IDLE
  - `data_req`, `data_wr`, `d_data_ok`, `d_ok_is_write` = 0
  - `rd` = 0; `data_addr`, `data_wdata`, `data_wstrb`, `data_size` = 0
- **Request timeline:**
  - Valid sampled in IDLE at cycle 0.
  - `data_req` = 1 from cycle 1 until the cycle in which `addr_ok` is seen, inclusive.
  - `data_data_ok` seen at cycle m → `d_data_ok` = 1 in cycle m+1 → IDLE at cycle m+2.
- **Minimum latency:** `addr_ok` and `data_ok` both arrive in cycle 1 → `d_data_ok` in cycle 2.
- **Throughput:** back-to-back requests occupy the bus at most once every 3 cycles (IDLE, REQ, DONE).
- **Reset mid-transaction:** `data_req` drops in the cycle after `reset` is sampled, and no `d_data_ok` is produced for the aborted request.
- **Registered outputs:** `rd` and `d_data_ok` are registered, with no combinational path from `data_rdata`. `data_*` outputs are registered or state-decoded only.

## Test plan
- **Zero-wait load:** `mread` addr 0x8000_1004, word; `addr_ok` and `data_ok` both in cycle 1 with `rdata` 0xDEADBEEF.
  - Required: `data_addr` 0x0000_1004, `data_wr` 0, `d_data_ok` pulse in cycle 2 with `rd` 0xDEADBEEF and `d_ok_is_write` 0.
- **Byte store with waits:** `mwrite` addr 0xA000_0003, size 0, data 0x7700_0000; `addr_ok` delayed 3 cycles, `data_ok` 2 cycles later.
  - Required: `data_addr` 0x0000_0003, `data_wstrb` 4'b1000, exactly one `d_data_ok` pulse with `d_ok_is_write` 1.
- **Simultaneous requests:** load and store valid in the same IDLE cycle.
  - Required: store transaction first, then, with the load still held, a load transaction starting at the following IDLE; two `d_data_ok` pulses with `d_ok_is_write` 1 then 0.
- **Held valid:** `mread_valid` kept high through DONE.
  - Required: no second transaction starts in DONE; a new request is captured only in the following IDLE cycle.
- **Mapping and strobes:**
  - `MAP_KSEG`=1, addr 0x1FC0_0000 → passes unchanged.
  - addr 0xC000_0000 → passes unchanged.
  - half store at addr 0x2 → `data_wstrb` 4'b1100.
- **Reset and stray response:** reset asserted in WAIT, then `data_data_ok` pulses in IDLE.
  - Required: state returns to IDLE, `d_data_ok` stays 0, `rd` stays 0.
